layer3_weight_loader: RTL and testbench

//   Writer side of the layer-3 weight store. Accepts a byte stream (valid/ready) of signed 8-bit weights,

---
 rtl/layer3_weight_loader_pkg.sv | 22 ++
 rtl/layer3_weight_loader.sv | 168 ++++++++++++++++
 tb/tb_layer3_weight_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer3_weight_loader_pkg.sv
// Shared definitions for the layer-3 weight loader: FSM encoding and derived widths.
package layer3_weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_NEURONS_DEF = 10;
    localparam int NUM_INPUTS_DEF  = 16;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_W = idx_width(NUM_NEURONS_DEF);
    localparam int DATA_W = NUM_INPUTS_DEF * 8;

endpackage

// File: rtl/layer3_weight_loader.sv
// Layer-3 weight loader: packs a byte stream into neuron rows and writes one row per neuron.
// Optional trailing checksum byte is enabled with the CHECKSUM_EN macro.
module layer3_weight_loader
    import layer3_weight_loader_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    localparam int AW = idx_width(NUM_NEURONS),
    localparam int DW = NUM_INPUTS * 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BW = idx_width(NUM_INPUTS);

    state_t        state_reg;
    state_t        state_next;
    logic [BW-1:0] byte_idx_reg;
    logic [AW-1:0] row_idx_reg;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [DW-1:0] wr_data_reg;
    logic          done_reg;
    logic [DW-1:0] row_full;

    logic start_take;
    logic accept;
    logic load_accept;
    logic byte_last;
    logic row_last;

    assign in_ready    = (state_reg == LOAD) || (state_reg == CHECK);
    assign busy        = in_ready;
    assign accept      = in_valid && in_ready;
    assign load_accept = accept && (state_reg == LOAD);
    assign start_take  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign byte_last   = (byte_idx_reg == BW'(NUM_INPUTS - 1));
    assign row_last    = (row_idx_reg == AW'(NUM_NEURONS - 1));

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign done    = done_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_accept && byte_last && row_last) begin
`ifdef CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef CHECKSUM_EN
                if (accept) begin
                    state_next = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // The last byte of a row bypasses storage and goes straight into the write word,
    // so the lane registers are free for the next row on the following cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_reg <= 8'h00;
                end else if (load_accept && (byte_idx_reg == BW'(gi))) begin
                    lane_reg <= in_byte;
                end
            end
            assign row_full[gi*8 +: 8] = lane_reg;
        end
    endgenerate
    assign row_full[DW-1 -: 8] = in_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
            row_idx_reg  <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            // done trails DONE entry by one cycle so it never overlaps the final write
            done_reg  <= (state_reg == DONE) && !start_take;
            if (start_take) begin
                byte_idx_reg <= '0;
                row_idx_reg  <= '0;
            end else if (load_accept) begin
                if (byte_last) begin
                    byte_idx_reg <= '0;
                    wr_en_reg    <= 1'b1;
                    wr_addr_reg  <= row_idx_reg;
                    wr_data_reg  <= row_full;
                    row_idx_reg  <= row_last ? '0 : row_idx_reg + AW'(1);
                end else begin
                    byte_idx_reg <= byte_idx_reg + BW'(1);
                end
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum_reg;
    logic       csum_bad_reg;
    logic       err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_reg     <= 8'h00;
            csum_bad_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (start_take) begin
                csum_reg     <= 8'h00;
                csum_bad_reg <= 1'b0;
            end else if (load_accept) begin
                csum_reg <= csum_reg + in_byte;
            end else if (accept && (state_reg == CHECK)) begin
                csum_bad_reg <= (in_byte != csum_reg);
            end
            err_reg <= (state_reg == DONE) && !start_take && csum_bad_reg;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer3_weight_loader.sv
// Self-checking bench for layer3_weight_loader: table of load scenarios plus hand-written corner sequences.
module tb_layer3_weight_loader;
    import layer3_weight_loader_pkg::*;

    localparam int NN    = 10;
    localparam int NI    = 16;
    localparam int AW    = 4;
    localparam int DW    = NI * 8;
    localparam int TOTAL = NN * NI;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    layer3_weight_loader #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        string name;
        int    pattern;     // 0 ramp, 1 min/max alternation, 2 random
        int    gap_pct;
        int    csum_delta;
        bit    exp_err;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] stream [TOTAL];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         write_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the next expected row.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            wr_t e;
            write_cnt++;
            check("done_during_write", DW'(done), DW'(1'b0));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", DW'(wr_addr), DW'(e.addr));
                check("wr_data", wr_data, e.data);
                $display("write addr=%0d data=%h", wr_addr, wr_data);
            end
        end
    end

    task automatic push_row(input int r);
        wr_t e;
        e.addr = AW'(r);
        for (int i = 0; i < NI; i++) e.data[i*8 +: 8] = stream[r*NI + i];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int from, input int to, input int gap_pct);
        for (int k = from; k < to; k++) begin
            if (k % NI == NI - 1) push_row(k / NI);
            send_byte(stream[k], gap_pct);
        end
    endtask

    task automatic begin_load();
        write_cnt = 0;
        pulse_start();
        check("busy_after_start", DW'(busy), DW'(1'b1));
        check("ready_after_start", DW'(in_ready), DW'(1'b1));
        check("done_cleared_on_start", DW'(done), DW'(1'b0));
        check("err_cleared_on_start", DW'(err), DW'(1'b0));
    endtask

    task automatic finish_load(input int csum_delta, input bit exp_err);
        logic [7:0] s;
        check("final_wr_latency", DW'(wr_en), DW'(1'b1));
        check("done_not_with_write", DW'(done), DW'(1'b0));
`ifdef CHECKSUM_EN
        s = 8'h00;
        for (int k = 0; k < TOTAL; k++) s = s + stream[k];
        s = s + 8'(csum_delta);
        send_byte(s, 0);
        check("done_after_csum", DW'(done), DW'(1'b0));
        @(posedge clk); #1;
        check("done_level", DW'(done), DW'(1'b1));
        check("err_level", DW'(err), DW'(exp_err));
`else
        s = 8'(csum_delta);
        @(posedge clk); #1;
        check("done_level", DW'(done), DW'(1'b1));
        check("err_level", DW'(err), DW'(1'b0 & exp_err & s[0]));
`endif
        check("busy_after_done", DW'(busy), DW'(1'b0));
        check("write_count", DW'(write_cnt), DW'(NN));
        check("scoreboard_empty", DW'(exp_q.size()), DW'(0));
        $display("load complete: writes=%0d done=%0d err=%0d", write_cnt, done, err);
    endtask

    task automatic fill(input int pattern);
        for (int k = 0; k < TOTAL; k++) begin
            case (pattern)
                0:       stream[k] = 8'(k);
                1:       stream[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
                default: stream[k] = 8'($urandom_range(255));
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vecs.push_back('{"ramp_full_rate", 0, 0, 0, 1'b0});
        vecs.push_back('{"ramp_gaps", 0, 30, 0, 1'b0});
        vecs.push_back('{"min_max", 1, 0, 0, 1'b0});
        vecs.push_back('{"random_gaps", 2, 30, 0, 1'b0});
`ifdef CHECKSUM_EN
        vecs.push_back('{"ramp_bad_csum", 0, 0, 1, 1'b1});
`endif

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", DW'(in_ready), DW'(1'b0));
        check("rst_wr_en", DW'(wr_en), DW'(1'b0));
        check("rst_busy", DW'(busy), DW'(1'b0));
        check("rst_done", DW'(done), DW'(1'b0));
        check("rst_err", DW'(err), DW'(1'b0));
        check("rst_wr_addr", DW'(wr_addr), DW'(0));
        check("rst_wr_data", wr_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < vecs.size(); v++) begin
            $display("scenario %s gap=%0d", vecs[v].name, vecs[v].gap_pct);
            fill(vecs[v].pattern);
            begin_load();
            run_stream(0, TOTAL, vecs[v].gap_pct);
            finish_load(vecs[v].csum_delta, vecs[v].exp_err);
        end

        // Reset in the middle of row 2: only rows 0 and 1 may have been written.
        $display("scenario reset_mid_load");
        fill(0);
        begin_load();
        run_stream(0, 40, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_wr_en", DW'(wr_en), DW'(1'b0));
        check("midrst_busy", DW'(busy), DW'(1'b0));
        check("midrst_done", DW'(done), DW'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("midrst_write_count", DW'(write_cnt), DW'(2));
        check("midrst_scoreboard", DW'(exp_q.size()), DW'(0));
        begin_load();
        run_stream(0, TOTAL, 0);
        finish_load(0, 1'b0);

        // start while loading must not disturb the row/byte counters.
        $display("scenario start_during_load");
        fill(2);
        begin_load();
        run_stream(0, 20, 0);
        pulse_start();
        check("start_in_load_busy", DW'(busy), DW'(1'b1));
        check("start_in_load_done", DW'(done), DW'(1'b0));
        run_stream(20, TOTAL, 0);
        finish_load(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
